// File: rtl/C.sv
// Core-wide types shared by the front end.
// Purpose: defines the decoded-instruction record (si_t) and the
// single-instruction RV32I decoder that every decode lane instantiates.
// Contents:
//   XLEN   - architectural register / PC width
//   si_t   - decoded instruction record passed from decode to rename
//   decode - pure function: raw 32-bit word + PC -> si_t
package C;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;     // 0 = illegal encoding, trap at retire
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic            rd_valid;  // writes a real register (never x0)
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            is_nop;    // canonical NOP or architectural hint
  } si_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic si_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    si_t        s;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       writesRd;
    s        = '0;
    op       = instr[6:0];
    f3       = instr[14:12];
    f7       = instr[31:25];
    writesRd = 1'b0;
    s.valid  = 1'b1;
    s.pc     = pc;
    s.instr  = instr;
    s.rd     = instr[11:7];
    s.rs1    = instr[19:15];
    s.rs2    = instr[24:20];
    case (op)
      OP_LUI, OP_AUIPC: begin
        s.imm    = {instr[31:12], 12'b0};
        writesRd = 1'b1;
      end
      OP_JAL: begin
        s.imm    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        writesRd = 1'b1;
      end
      OP_JALR: begin
        s.imm    = {{20{instr[31]}}, instr[31:20]};
        writesRd = 1'b1;
        s.valid  = (f3 == 3'd0);
      end
      OP_BRANCH: begin
        s.imm   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        s.valid = (f3 != 3'd2) && (f3 != 3'd3);
      end
      OP_LOAD: begin
        s.imm    = {{20{instr[31]}}, instr[31:20]};
        writesRd = 1'b1;
        s.valid  = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      OP_STORE: begin
        s.imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        s.valid = (f3 <= 3'd2);
      end
      OP_IMM: begin
        s.imm    = {{20{instr[31]}}, instr[31:20]};
        writesRd = 1'b1;
        // shift-immediates reuse the upper bits as funct7
        if (f3 == 3'd1)      s.valid = (f7 == 7'h00);
        else if (f3 == 3'd5) s.valid = (f7 == 7'h00) || (f7 == 7'h20);
      end
      OP_REG: begin
        writesRd = 1'b1;
        s.valid  = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      end
      OP_FENCE: begin
        s.imm = {{20{instr[31]}}, instr[31:20]};
      end
      OP_SYSTEM: begin
        s.imm    = {{20{instr[31]}}, instr[31:20]};
        writesRd = (f3 != 3'd0);
      end
      default: s.valid = 1'b0;
    endcase
    // computational ops that target x0 have no effect: treat them as NOPs
    s.is_nop   = s.valid && (s.rd == 5'd0) &&
                 ((op == OP_IMM) || (op == OP_REG) || (op == OP_LUI) || (op == OP_AUIPC));
    s.rd_valid = s.valid && writesRd && (s.rd != 5'd0);
    return s;
  endfunction

endpackage

// File: rtl/decode_queue.sv
// decode_queue: N-wide decode stage between fetch and rename.
// Decodes up to NLANES instructions per cycle, compacts the active lanes in
// program order into a DEPTH-entry circular queue and exposes the NLANES
// oldest entries to rename. Intake stops after an illegal instruction until
// a flush, so the trap retires in order with nothing queued behind it.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   flush_i               empty queue, return to RUN
//   fetch_valid_i/_ready_o fetch packet handshake
//   pc_i, data_i          lane-0 PC and raw instruction words
//   lane_mask_i           active lanes (any pattern)
//   si_o, si_valid_o      head window, thermometer valid
//   pop_i                 entries consumed from the head this cycle
//   count_o               registered occupancy
//   halted_o              intake halted on an illegal instruction
module decode_queue #(
  parameter int NLANES = 2,
  parameter int DEPTH  = 8,
  parameter int CW     = $clog2(DEPTH + 1),
  parameter int PW     = $clog2(NLANES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [C::XLEN-1:0]       pc_i,
  input  logic [NLANES-1:0][31:0]  data_i,
  input  logic [NLANES-1:0]        lane_mask_i,
  output C::si_t [NLANES-1:0]      si_o,
  output logic [NLANES-1:0]        si_valid_o,
  input  logic [PW-1:0]            pop_i,
  output logic [CW-1:0]            count_o,
  output logic                     halted_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int XL = C::XLEN;

  typedef enum logic {RUN, HALT} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   headPtr_q, headPtr_d, tailPtr_q, tailPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   popEff, freeSlots;
  C::si_t          mem_q [DEPTH];
  C::si_t          dec [NLANES];
  logic [NLANES-1:0] wrEn;
  logic [AW-1:0]   wrIdx [NLANES];
  logic [PW-1:0]   enqCount;
  logic            accept, haltHit;

  // ready depends only on registered state so pop/flush never reach it
  assign freeSlots     = CW'(DEPTH) - count_q;
  assign fetch_ready_o = (state_q == RUN) && (freeSlots >= CW'(NLANES));
  assign accept        = fetch_valid_i && fetch_ready_o && !flush_i;
  assign popEff        = (CW'(pop_i) > count_q) ? count_q : CW'(pop_i);
  assign halted_o      = (state_q == HALT);
  assign count_o       = count_q;

  // Per-lane decode and compaction: each active lane takes the next free
  // slot; the first illegal lane is kept and everything above it is dropped.
  always_comb begin
    enqCount = '0;
    haltHit  = 1'b0;
    wrEn     = '0;
    for (int k = 0; k < NLANES; k++) begin
      dec[k]   = C::decode(data_i[k], pc_i + XL'(4 * k));
      wrIdx[k] = tailPtr_q + AW'(enqCount);
      if (accept && lane_mask_i[k] && !haltHit) begin
        wrEn[k]  = 1'b1;
        enqCount = enqCount + PW'(1);
        if (!dec[k].valid) haltHit = 1'b1;
      end
    end
  end

  // Next-state: flush overrides enqueue, pop and halt in the same cycle.
  always_comb begin
    state_d   = state_q;
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    if (flush_i) begin
      state_d   = RUN;
      headPtr_d = '0;
      tailPtr_d = '0;
      count_d   = '0;
    end else begin
      headPtr_d = headPtr_q + AW'(popEff);
      tailPtr_d = tailPtr_q + AW'(enqCount);
      count_d   = count_q + CW'(enqCount) - popEff;
      if (haltHit) state_d = HALT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  // Entry storage carries no reset; validity comes from count_q alone.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NLANES; k++) begin
      if (wrEn[k]) mem_q[wrIdx[k]] <= dec[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NLANES; k++) begin
      si_o[k]       = mem_q[headPtr_q + AW'(k)];
      si_valid_o[k] = (CW'(k) < count_q);
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert ((int'(count_q) + int'(enqCount) >= int'(popEff)) &&
              (int'(count_q) + int'(enqCount) - int'(popEff) <= DEPTH))
        else $error("decode_queue: occupancy out of range");
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue with NLANES=2, DEPTH=4.
// A table of directed vectors covers steady flow, compaction, backpressure,
// illegal-instruction halt and flush priority; hand-written sequences cover
// pointer wrap with over-pop and an asynchronous reset mid-operation.
module tb_decode_queue;

  localparam int NL = 2;
  localparam int DP = 4;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] ILL  = 32'hFFFFFFFF;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                fetchValid;
  logic                fetchReady;
  logic [31:0]         pc;
  logic [NL-1:0][31:0] data;
  logic [NL-1:0]       mask;
  C::si_t [NL-1:0]     si;
  logic [NL-1:0]       siValid;
  logic [1:0]          pop;
  logic [2:0]          count;
  logic                halted;

  int numVectors     = 0;
  int numMiscompares = 0;

  typedef struct {
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  mask;
    logic [1:0]  pop;
    int          expCount;
    logic [1:0]  expSiValid;
    logic        expReady;
    logic        expHalted;
    logic        chkHead;
    logic [31:0] expPc0;
    logic        expLegal0;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] modelQ[$];
  logic [1:0]  wMask  [12];
  logic [1:0]  wPop   [12];
  logic        wValid [12];

  decode_queue #(.NLANES(NL), .DEPTH(DP)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .fetch_valid_i(fetchValid),
    .fetch_ready_o(fetchReady),
    .pc_i         (pc),
    .data_i       (data),
    .lane_mask_i  (mask),
    .si_o         (si),
    .si_valid_o   (siValid),
    .pop_i        (pop),
    .count_o      (count),
    .halted_o     (halted)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic fl, input logic va, input logic [31:0] p,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] m, input logic [1:0] pp,
                              input int cnt, input logic [1:0] sv, input logic rdy,
                              input logic hlt, input logic ch, input logic [31:0] pc0,
                              input logic lg);
    vec_t v;
    v.flush = fl; v.valid = va; v.pc = p; v.d0 = d0; v.d1 = d1; v.mask = m; v.pop = pp;
    v.expCount = cnt; v.expSiValid = sv; v.expReady = rdy; v.expHalted = hlt;
    v.chkHead = ch; v.expPc0 = pc0; v.expLegal0 = lg;
    return v;
  endfunction

  task automatic applyStimulus(input logic fl, input logic va, input logic [31:0] p,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [1:0] m, input logic [1:0] pp);
    flush      = fl;
    fetchValid = va;
    pc         = p;
    data[0]    = d0;
    data[1]    = d1;
    mask       = m;
    pop        = pp;
  endtask

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
      numMiscompares++;
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " count"}, 32'(count), 32'd0);
    checkOutput({tag, " siValid"}, 32'(siValid), 32'd0);
    checkOutput({tag, " ready"}, 32'(fetchReady), 32'd1);
    checkOutput({tag, " halted"}, 32'(halted), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic prevReady;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, ADDI, ADDI, 2'b00, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    numVectors++;
    checkIdle("in-reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    numVectors++;
    checkIdle("post-reset");

    //            fl va pc          d0    d1    mask   pop   cnt sv     rdy hlt chk pc0         legal
    vecs.push_back(mk(0, 1, 32'h1000, ADDI, ADDI, 2'b11, 2'd2, 2, 2'b11, 1, 0, 1, 32'h1000, 1));
    vecs.push_back(mk(0, 1, 32'h1008, ADDI, ADDI, 2'b11, 2'd2, 2, 2'b11, 1, 0, 1, 32'h1008, 1));
    vecs.push_back(mk(0, 1, 32'h1010, ADDI, ADDI, 2'b11, 2'd2, 2, 2'b11, 1, 0, 1, 32'h1010, 1));
    vecs.push_back(mk(0, 1, 32'h1018, ADDI, ADDI, 2'b11, 2'd2, 2, 2'b11, 1, 0, 1, 32'h1018, 1));
    vecs.push_back(mk(0, 0, 32'h0,    ADDI, ADDI, 2'b00, 2'd2, 0, 2'b00, 1, 0, 0, 32'h0,    1));
    vecs.push_back(mk(0, 1, 32'h2000, ADDI, ADDI, 2'b10, 2'd0, 1, 2'b01, 1, 0, 1, 32'h2004, 1));
    vecs.push_back(mk(0, 1, 32'h3000, ADDI, ADDI, 2'b01, 2'd0, 2, 2'b11, 1, 0, 1, 32'h2004, 1));
    vecs.push_back(mk(0, 1, 32'h3100, ADDI, ADDI, 2'b01, 2'd0, 3, 2'b11, 0, 0, 1, 32'h2004, 1));
    vecs.push_back(mk(0, 1, 32'h3200, ADDI, ADDI, 2'b11, 2'd1, 2, 2'b11, 1, 0, 1, 32'h3000, 1));
    vecs.push_back(mk(0, 0, 32'h0,    ADDI, ADDI, 2'b00, 2'd2, 0, 2'b00, 1, 0, 0, 32'h0,    1));
    vecs.push_back(mk(0, 1, 32'h4000, ILL,  ADDI, 2'b11, 2'd0, 1, 2'b01, 0, 1, 1, 32'h4000, 0));
    vecs.push_back(mk(0, 1, 32'h4100, ADDI, ADDI, 2'b11, 2'd1, 0, 2'b00, 0, 1, 0, 32'h0,    1));
    vecs.push_back(mk(0, 0, 32'h0,    ADDI, ADDI, 2'b00, 2'd0, 0, 2'b00, 0, 1, 0, 32'h0,    1));
    vecs.push_back(mk(1, 1, 32'h4200, ADDI, ADDI, 2'b11, 2'd0, 0, 2'b00, 1, 0, 0, 32'h0,    1));
    vecs.push_back(mk(0, 1, 32'h5000, ADDI, ADDI, 2'b11, 2'd0, 2, 2'b11, 1, 0, 1, 32'h5000, 1));
    vecs.push_back(mk(0, 1, 32'h5008, ADDI, ADDI, 2'b01, 2'd0, 3, 2'b11, 0, 0, 1, 32'h5000, 1));
    vecs.push_back(mk(1, 1, 32'h6000, ADDI, ADDI, 2'b11, 2'd2, 0, 2'b00, 1, 0, 0, 32'h0,    1));
    vecs.push_back(mk(0, 1, 32'h7000, ADDI, ADDI, 2'b01, 2'd0, 1, 2'b01, 1, 0, 1, 32'h7000, 1));
    vecs.push_back(mk(0, 1, 32'h7100, ADDI, ILL,  2'b11, 2'd0, 3, 2'b11, 0, 1, 1, 32'h7000, 1));
    vecs.push_back(mk(1, 0, 32'h0,    ADDI, ADDI, 2'b00, 2'd0, 0, 2'b00, 1, 0, 0, 32'h0,    1));
    vecs.push_back(mk(0, 1, 32'h7200, ILL,  ADDI, 2'b10, 2'd0, 1, 2'b01, 1, 0, 1, 32'h7204, 1));
    vecs.push_back(mk(1, 0, 32'h0,    ADDI, ADDI, 2'b00, 2'd0, 0, 2'b00, 1, 0, 0, 32'h0,    1));

    prevReady = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].flush, vecs[i].valid, vecs[i].pc, vecs[i].d0, vecs[i].d1,
                    vecs[i].mask, vecs[i].pop);
      #1;
      // ready must not react to pop/flush/fetch inputs before the edge
      checkOutput($sformatf("v%0d preReady", i), 32'(fetchReady), 32'(prevReady));
      @(posedge clk);
      #1;
      numVectors++;
      checkOutput($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].expCount));
      checkOutput($sformatf("v%0d siValid", i), 32'(siValid), 32'(vecs[i].expSiValid));
      checkOutput($sformatf("v%0d ready", i), 32'(fetchReady), 32'(vecs[i].expReady));
      checkOutput($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].expHalted));
      if (vecs[i].chkHead) begin
        checkOutput($sformatf("v%0d pc0", i), si[0].pc, vecs[i].expPc0);
        checkOutput($sformatf("v%0d legal0", i), 32'(si[0].valid), 32'(vecs[i].expLegal0));
      end
      prevReady = vecs[i].expReady;
    end

    // Wrap sequence: mixed masks and pops, including over-pop at count 1.
    wMask  = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b11};
    wPop   = '{2'd0,  2'd1,  2'd2,  2'd0,  2'd2,  2'd1,  2'd2,  2'd2,  2'd0,  2'd2,  2'd2,  2'd0};
    wValid = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
    modelQ.delete();
    for (int c = 0; c < 12; c++) begin
      logic [31:0] base;
      logic        expRdy;
      int          pe;
      int          sz;
      base = 32'h8000 + 32'(c * 8);
      applyStimulus(1'b0, wValid[c], base, ADDI, ADDI, wMask[c], wPop[c]);
      #1;
      sz     = modelQ.size();
      expRdy = (sz <= DP - NL);
      checkOutput($sformatf("wrap%0d ready", c), 32'(fetchReady), 32'(expRdy));
      checkOutput($sformatf("wrap%0d siValid", c), 32'(siValid),
                  (sz >= 2) ? 32'd3 : ((sz == 1) ? 32'd1 : 32'd0));
      pe = (int'(wPop[c]) > sz) ? sz : int'(wPop[c]);
      for (int k = 0; k < pe; k++) begin
        checkOutput($sformatf("wrap%0d pc%0d", c, k), si[k].pc, modelQ[0]);
        void'(modelQ.pop_front());
      end
      if (wValid[c] && expRdy) begin
        for (int l = 0; l < NL; l++) begin
          if (wMask[c][l]) modelQ.push_back(base + 32'(4 * l));
        end
      end
      @(posedge clk);
      #1;
      numVectors++;
      checkOutput($sformatf("wrap%0d count", c), 32'(count), 32'(modelQ.size()));
    end
    checkOutput("wrap-end pc0", si[0].pc, 32'h8058);
    checkOutput("wrap-end pc1", si[1].pc, 32'h805C);

    // Halt, then an asynchronous reset in the middle of the cycle.
    applyStimulus(1'b0, 1'b1, 32'h9000, ILL, ADDI, 2'b01, 2'd0);
    @(posedge clk);
    #1;
    numVectors++;
    checkOutput("halt-pre-rst halted", 32'(halted), 32'd1);
    checkOutput("halt-pre-rst count", 32'(count), 32'd3);
    checkOutput("halt-pre-rst ready", 32'(fetchReady), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, ADDI, ADDI, 2'b00, 2'd0);
    #2;
    rst = 1'b1;
    #1;
    numVectors++;
    checkIdle("async-rst");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    numVectors++;
    checkIdle("after-async-rst");

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
